// File: rtl/i2s_tx_stereo_slave.sv
// Device-side I2S transmitter: oversamples external BCLK/WS and shifts stereo words out MSB-first
// with the one-bit I2S delay. Define I2S_TX_SD_OE_EN to add the sd_oe tristate-enable output.
module i2s_tx_stereo_slave #(
   parameter int WORD_WIDTH  = 24,
   parameter int SYNC_STAGES = 2
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic                         bclk_in,
   input  logic                         lrclk_in,
   input  logic signed [WORD_WIDTH-1:0] left_in,
   input  logic signed [WORD_WIDTH-1:0] right_in,
   input  logic                         in_valid,
   output logic                         in_ready,
   output logic                         sdata,
   output logic                         frame_start,
`ifdef I2S_TX_SD_OE_EN
   output logic                         sd_oe,
`endif
   output logic                         underrun
);

   typedef enum logic {ST_SEEK = 1'b0, ST_RUN = 1'b1} state_t;

   localparam logic [5:0] W_LEN   = 6'(WORD_WIDTH);
   localparam logic [5:0] CNT_MAX = 6'd63;

   logic [SYNC_STAGES-1:0] r_bclk_sync;
   logic [SYNC_STAGES-1:0] r_lrclk_sync;
   logic                   r_bclk_d;
   logic                   r_ws_s;
   logic                   r_ws_prev;
   state_t                 r_state;
   logic [WORD_WIDTH-1:0]  r_hold_l;
   logic [WORD_WIDTH-1:0]  r_hold_r;
   logic                   r_hold_full;
   logic [WORD_WIDTH-1:0]  r_act_l;
   logic [WORD_WIDTH-1:0]  r_act_r;
   logic [WORD_WIDTH-1:0]  r_shift;
   logic [5:0]             r_bit_cnt;
   logic                   r_sdata;
   logic                   r_frame_start;
   logic                   r_underrun;
`ifdef I2S_TX_SD_OE_EN
   logic                   r_sd_oe;
`endif

   logic                   w_bclk_s;
   logic                   w_rise;
   logic                   w_fall;
   logic                   w_slot_edge;
   logic                   w_slot_start;
   logic                   w_left_start;
   logic                   w_load;
   logic                   w_accept;
   logic [WORD_WIDTH-1:0]  w_start_word;

   assign w_bclk_s     = r_bclk_sync[SYNC_STAGES-1];
   assign w_rise       = w_bclk_s & ~r_bclk_d;
   assign w_fall       = ~w_bclk_s & r_bclk_d;
   assign w_slot_edge  = r_ws_s ^ r_ws_prev;
   // A 0->1 edge only counts once running; a 1->0 edge starts a left slot in either state.
   assign w_slot_start = w_fall & w_slot_edge & ((r_state == ST_RUN) | ~r_ws_s);
   assign w_left_start = w_slot_start & ~r_ws_s;
   assign w_load       = w_left_start & r_hold_full;
   assign w_accept     = in_valid & ~r_hold_full;
   assign w_start_word = r_ws_s ? r_act_r : (r_hold_full ? r_hold_l : r_act_l);

   assign in_ready    = ~r_hold_full;
   assign sdata       = r_sdata;
   assign frame_start = r_frame_start;
   assign underrun    = r_underrun;
`ifdef I2S_TX_SD_OE_EN
   assign sd_oe       = r_sd_oe;
`endif

   // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_bclk_sync  <= '0;
         r_lrclk_sync <= '0;
         r_bclk_d     <= 1'b0;
      end else begin
         r_bclk_sync  <= {r_bclk_sync[SYNC_STAGES-2:0], bclk_in};
         r_lrclk_sync <= {r_lrclk_sync[SYNC_STAGES-2:0], lrclk_in};
         r_bclk_d     <= w_bclk_s;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_ws_s        <= 1'b0;
         r_ws_prev     <= 1'b0;
         r_state       <= ST_SEEK;
         r_hold_l      <= '0;
         r_hold_r      <= '0;
         r_hold_full   <= 1'b0;
         r_act_l       <= '0;
         r_act_r       <= '0;
         r_shift       <= '0;
         r_bit_cnt     <= '0;
         r_sdata       <= 1'b0;
         r_frame_start <= 1'b0;
         r_underrun    <= 1'b0;
`ifdef I2S_TX_SD_OE_EN
         r_sd_oe       <= 1'b0;
`endif
      end else begin
         r_frame_start <= 1'b0;
         r_underrun    <= 1'b0;

         // WS is captured mid-bit on the rise and compared across consecutive falls.
         if (w_rise) r_ws_s    <= r_lrclk_sync[SYNC_STAGES-1];
         if (w_fall) r_ws_prev <= r_ws_s;

         // Accept and load are exclusive: accept needs an empty buffer, load a full one.
         if (w_accept) begin
            r_hold_l    <= left_in;
            r_hold_r    <= right_in;
            r_hold_full <= 1'b1;
         end else if (w_load) begin
            r_hold_full <= 1'b0;
         end

         if (w_load) begin
            r_act_l <= r_hold_l;
            r_act_r <= r_hold_r;
         end

         if (w_slot_start) begin
            r_state   <= ST_RUN;
            r_sdata   <= w_start_word[WORD_WIDTH-1];
            r_shift   <= w_start_word << 1;
            r_bit_cnt <= 6'd1;
`ifdef I2S_TX_SD_OE_EN
            r_sd_oe   <= 1'b1;
`endif
            if (w_left_start) begin
               r_frame_start <= 1'b1;
               r_underrun    <= ~r_hold_full;
            end
         end else if (w_fall && (r_state == ST_RUN)) begin
            if (r_bit_cnt < W_LEN) begin
               r_sdata <= r_shift[WORD_WIDTH-1];
               r_shift <= r_shift << 1;
`ifdef I2S_TX_SD_OE_EN
               r_sd_oe <= 1'b1;
`endif
            end else begin
               r_sdata <= 1'b0;
`ifdef I2S_TX_SD_OE_EN
               r_sd_oe <= 1'b0;
`endif
            end
            if (r_bit_cnt != CNT_MAX) r_bit_cnt <= r_bit_cnt + 6'd1;
         end
      end
   end

endmodule

// File: doc/i2s_tx_stereo_slave.md
Name: i2s_tx_stereo_slave

Overview:
- Device-side I2S serializer, the transmit counterpart to the mic-style receivers: emulates an I2S source (INMP441-style mic or ADC) driving SD from externally supplied BCLK/WS.
- Runs entirely on the system clock and oversamples bclk_in/lrclk_in. Never generates I2S clocks.
- Accepts stereo sample pairs through a valid/ready handshake into a one-pair holding buffer.
- Serializes MSB-first with the standard one-bit I2S delay.

Parameters:
- WORD_WIDTH, 24: bits per channel word sent MSB-first; must be <= 31.
- SYNC_STAGES, 2: synchronizer flops on bclk_in and lrclk_in; must be >= 2.

Ports:
- clk  input  1  system clock; must be >= 8x the bclk_in frequency.
- reset_n  input  1  asynchronous active-low reset.
- bclk_in  input  1  external I2S bit clock (asynchronous).
- lrclk_in  input  1  external word select; 0 = left, 1 = right.
- left_in  input  WORD_WIDTH  signed left sample.
- right_in  input  WORD_WIDTH  signed right sample.
- in_valid  input  1  sample pair offered.
- in_ready  output  1  holding buffer empty.
- sdata  output  1  serial data out.
- frame_start  output  1  1-clk pulse when a left slot begins in RUN.
- underrun  output  1  1-clk pulse when a left slot begins with the holding buffer empty.

Behaviour:
- Reset (reset_n=0, async): synchronizers 0, sdata=0, in_ready=1, frame_start=0, underrun=0, hold/active registers 0, bit_cnt=0, ws_s=0, ws_prev=0, state=SEEK.
- Edge detection:
  - bclk_s is the last synchronizer stage; bclk_d is bclk_s delayed one clk.
  - rise = bclk_d=0 & bclk_s=1; fall = bclk_d=1 & bclk_s=0.
- On rise: ws_s <= lrclk_sync. WS is sampled mid-bit, never at its own transition edge.
- On fall: ws_prev <= ws_s. A slot edge is ws_s != ws_prev.
- States:
  - SEEK: sdata held 0; slot edges 0->1 are ignored. A 1->0 slot edge enters RUN and is handled as a left-slot start in that same fall.
  - RUN: every fall updates sdata, as below.
- Slot start (fall with slot edge, in RUN or on SEEK exit):
  - Left start (ws_s=0):
    - If hold_full: active pair <= hold pair; hold_full <= 0.
    - Else: active pair unchanged (previous pair repeats) and underrun pulses.
    - Either way: frame_start pulses; shift <= active left (the newly loaded value if loaded).
  - Right start (ws_s=1): shift <= active right.
  - In both cases sdata <= new word MSB and bit_cnt <= 1.
- Non-edge fall in RUN:
  - bit_cnt < WORD_WIDTH: sdata <= next bit, MSB-first.
  - Otherwise sdata <= 0.
  - bit_cnt saturates at 63, so over-long slots pad zeros.
- One-bit delay: WS changes at physical fall N and ws_s updates at rise N+0.5, so the MSB appears at fall N+1, as I2S requires.
- Latency: sdata changes SYNC_STAGES+1 clk after the physical bclk falling edge.
- Handshake:
  - in_ready = ~hold_full. Accept when in_valid & in_ready; hold <= {left_in, right_in}; hold_full <= 1.
  - Accept in the same clk as a left-start transfer: only possible when hold was empty. Underrun pulses, active repeats, and the new pair lands in hold.
  - in_valid while not ready: ignored, no data change.
- Reset mid-slot: sdata drops to 0 immediately; after release the block re-enters SEEK and waits for the next 1->0 WS edge. Half-slots never resume.
- Underrun and frame_start are never asserted in SEEK.

Optional Feature:
- Macro: I2S_TX_SD_OE_EN.
- Defined: adds output port sd_oe (1 bit, reset 0), updated on the same fall as sdata.
  - sd_oe = 1 in RUN while bit_cnt is in 1..WORD_WIDTH, i.e. the data bits of either slot; 0 otherwise, including SEEK and the padding bits.
  - The top level uses sd_oe to tristate SD, matching mic behaviour on a shared line.
- Undefined: no sd_oe port; sdata is always driven, with zeros outside data bits.

Test Plan:
- Basic serialization:
  - Stimulus: clk 50 MHz, bclk 3.072 MHz, 64 BCLK/frame. Push L=24'hA5F00F, R=24'h123456 before the first left edge.
  - Required: left slot fall 1..24 shifts A5F00F MSB-first, right slot shifts 123456, falls 25..32 are 0; frame_start pulses once per frame.
- Startup alignment:
  - Stimulus: release reset with lrclk_in=1 mid-right-slot.
  - Required: sdata stays 0, no frame_start/underrun, until the next 1->0 WS edge. The first data bit is the left MSB, one BCLK after WS falls.
- Underrun:
  - Stimulus: send one pair 24'h000001/24'hFFFFFF, then no further pairs.
  - Required: the second frame repeats the same pair; underrun pulses once per frame from frame 2 on; in_ready stays 1.
- Backpressure:
  - Stimulus: hold in_valid=1 continuously with an incrementing pair.
  - Required: in_ready deasserts after one accept and reasserts 1 clk after each left start. Exactly one pair is consumed per frame, none lost, none duplicated.
- Reset mid-word:
  - Stimulus: assert reset_n=0 at bit 10 of a left slot.
  - Required: sdata is 0 within the same clk. After release, the block waits a full SEEK period; the held pair is cleared and in_ready=1.
- Output enable:
  - With I2S_TX_SD_OE_EN defined, sd_oe is high for exactly 24 falls per slot and low for SEEK and the padding bits.
